alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the ALU operand/opcode interface (R2, R3, ALUOp in; R0, Overflow, Zero, Carry out).
//  Accepts one register-to-register instruction at a time and reads operands from a 4-entry register file.
//  Drives them to the clocked ALU, waits ALU_LAT cycles and writes R0 back to the register file.
//  Presents result plus flags on a valid/ready response port. Sits between the instruction source and the ALU.
// PARAMETERS
//  N        32  datapath width (register file, ALU operands, result)
//  ALU_LAT  1   clk edges from stable operands to valid ALU outputs; legal 0..15
// PORTS
//  clk           in   1    single clock, all state on rising edge
//  rst           in   1    asynchronous, active-high reset
//  instr_valid   in   1    instruction offered
//  instr_ready   out  1    controller can accept instruction
//  instr_op      in   3    ALUOp: 000 MOV,001 NOT,010 ADD,011 NOR,100 SUB,101 NAND,110 AND,111 SLT
//  instr_rs      in   2    source reg -> R2
//  instr_rt      in   2    source reg -> R3
//  instr_rd      in   2    destination reg
//  ld_en         in   1    direct register-file load strobe
//  ld_addr       in   2    load target
//  ld_data       in   N    load value
//  alu_r2        out  N    ALU operand R2
//  alu_r3        out  N    ALU operand R3
//  alu_op        out  3    ALU opcode
//  alu_r0        in   N    ALU result
//  alu_ovf       in   1    ALU Overflow
//  alu_zero      in   1    ALU Zero
//  alu_carry     in   1    ALU Carry
//  res_valid     out  1    result held for consumer
//  res_ready     in   1    consumer accepts result
//  res_data      out  N    captured R0
//  res_flags     out  3    {ovf,zero,carry} captured with res_data
//  busy          out  1    state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; rf[0..3], operand regs, alu_r2/r3/op, res_data, res_flags = 0; res_valid = 0.
//  Reset: busy = 0; instr_ready = 0 while rst high, 1 after.
//  Reset mid-operation aborts: no rf write, in-flight ALU output ignored, pending result dropped.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: instr_ready=1; accept on instr_valid&&instr_ready.
//   - Latch op, rd, rf[rs] -> alu_r2, rf[rt] -> alu_r3; cnt <= ALU_LAT; go EXEC.
//  EXEC: alu_r2/alu_r3/alu_op held constant (ALU sees stable inputs).
//   - cnt != 0: cnt decrements each edge.
//   - cnt == 0: at that edge rf[rd] <= alu_r0; res_data <= alu_r0; res_flags <= {alu_ovf,alu_zero,alu_carry};
//     res_valid <= 1; go RESP.
//  RESP: res_valid=1, res_data/res_flags stable until res_ready; on res_valid&&res_ready -> IDLE next edge.
//   - res_ready already high on entry: one-cycle RESP.
//  Latency: accept edge to res_valid = ALU_LAT+1 edges. Min issue interval ALU_LAT+3 cycles with res_ready tied 1.
//  instr_ready=0 in EXEC and RESP; instr_valid there is ignored, not queued.
//  Operands are read at the accept edge. rs==rt legal; rd may equal rs/rt (overwrite after read).
//  Load port: ld_en honoured only in IDLE; ld_en in EXEC/RESP is dropped.
//   - ld_en with an accept in the same IDLE cycle: operands read pre-load values, then load commits.
//   - A later write of the same rd by the instruction wins.
//  Arithmetic: controller does no arithmetic; widths pass through unmodified. rf has no hardwired zero.
//  alu_op/alu_r2/alu_r3 keep last issued values in IDLE/RESP (no toggling between instructions).
// TESTING
//  1 Reset: assert rst mid-EXEC (after ld + ADD issue) -> rf reads 0, res_valid=0, instr_ready=1 one cycle after release.
//  2 ld r1=1000, r2=999; ADD rd=3 rs=1 rt=2, ALU_LAT=1, res_ready=1 -> res_valid 2 edges after accept, res_data=1999; rf[3]=1999.
//  3 ld r0=32'hFFFFFFFF, r1=32'hFFFFFFFF; SUB rd=2 rs=0 rt=1 -> res_data=0, res_flags[1] (zero)=1.
//  4 Backpressure: res_ready=0 for 5 cycles after res_valid -> res_data/flags stable, instr_ready=0; accept -> IDLE next edge.
//  5 SLT r0=32'hFFFFFFFF, r1=5 -> res_data=1; then ld_en during EXEC of NOT -> load ignored; ld + accept same cycle -> old operand used.
//  6 Back-to-back MOV r1->r2 then ADD r2+r2 into r2 (r1=21) -> second result 42, rf[2]=42; repeat with ALU_LAT=0 and 3.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a clocked ALU: reads two operands from a 4-entry register file,
// waits ALU_LAT edges for the ALU result, writes it back and offers it on a valid/ready port.
module alu_issue_ctrl #(
    parameter int N       = 32,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [2:0]   instr_op,
    input  logic [1:0]   instr_rs,
    input  logic [1:0]   instr_rt,
    input  logic [1:0]   instr_rd,
    input  logic         ld_en,
    input  logic [1:0]   ld_addr,
    input  logic [N-1:0] ld_data,
    output logic [N-1:0] alu_r2,
    output logic [N-1:0] alu_r3,
    output logic [2:0]   alu_op,
    input  logic [N-1:0] alu_r0,
    input  logic         alu_ovf,
    input  logic         alu_zero,
    input  logic         alu_carry,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic [2:0]   res_flags,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     cnt;
    logic [1:0]     rd_p0;
    logic [N-1:0]   rf [4];

    logic           accept;
    logic           ld_fire;
    logic           capture;
    logic           res_done;

    // Nothing is accepted while reset is held, even though the state is already IDLE.
    assign instr_ready = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ld_fire   = 1'b0;
        capture   = 1'b0;
        res_done  = 1'b0;
        case (state)
            IDLE: begin
                ld_fire = ld_en;
                if (instr_valid && instr_ready) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latency counter: loaded on accept, the ALU output is sampled once it reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= LAT_INIT;
        end else if (state == EXEC && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Operand stage: held from accept until the next accept so the ALU inputs never toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_r2 <= '0;
            alu_r3 <= '0;
            alu_op <= 3'd0;
            rd_p0  <= 2'd0;
        end else if (accept) begin
            alu_r2 <= rf[instr_rs];
            alu_r3 <= rf[instr_rt];
            alu_op <= instr_op;
            rd_p0  <= instr_rd;
        end
    end

    // Register file: a same-cycle load and accept reads the old contents; writeback and
    // loads are never simultaneous because loads only commit in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rf[i] <= '0;
            end
        end else if (capture) begin
            rf[rd_p0] <= alu_r0;
        end else if (ld_fire) begin
            rf[ld_addr] <= ld_data;
        end
    end

    // Response stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data  <= '0;
            res_flags <= 3'd0;
            res_valid <= 1'b0;
        end else if (capture) begin
            res_data  <= alu_r0;
            res_flags <= {alu_ovf, alu_zero, alu_carry};
            res_valid <= 1'b1;
        end else if (res_done) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: three instances (ALU_LAT 0, 1, 3), each paired with a behavioural
// ALU, driven by directed and random instructions and compared against a register-file model.
module tb_alu_issue_ctrl;
    localparam int N  = 32;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         instr_valid [NI];
    logic         instr_ready [NI];
    logic [2:0]   instr_op    [NI];
    logic [1:0]   instr_rs    [NI];
    logic [1:0]   instr_rt    [NI];
    logic [1:0]   instr_rd    [NI];
    logic         ld_en       [NI];
    logic [1:0]   ld_addr     [NI];
    logic [N-1:0] ld_data     [NI];
    logic [N-1:0] alu_r2      [NI];
    logic [N-1:0] alu_r3      [NI];
    logic [2:0]   alu_op      [NI];
    logic [N-1:0] alu_r0      [NI];
    logic         alu_ovf     [NI];
    logic         alu_zero    [NI];
    logic         alu_carry   [NI];
    logic         res_valid   [NI];
    logic         res_ready   [NI];
    logic [N-1:0] res_data    [NI];
    logic [2:0]   res_flags   [NI];
    logic         busy        [NI];

    int checks = 0;
    int errors = 0;
    int cur_k  = 0;
    logic [N-1:0] rf_m [4];

    function automatic int lat_of(int k);
        return (k == 0) ? 0 : (k == 1) ? 1 : 3;
    endfunction

    // Returns {ovf, zero, carry, result}.
    function automatic logic [N+2:0] alu_fn(logic [2:0] op, logic [N-1:0] a, logic [N-1:0] b);
        logic [N:0]   s;
        logic [N-1:0] r;
        logic         o;
        logic         c;
        o = 1'b0;
        c = 1'b0;
        s = '0;
        case (op)
            3'd0: r = a;
            3'd1: r = ~a;
            3'd2: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[N-1:0];
                c = s[N];
                o = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            3'd3: r = ~(a | b);
            3'd4: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[N-1:0];
                c = ~s[N];
                o = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            3'd5: r = ~(a & b);
            3'd6: r = a & b;
            default: r = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
        endcase
        return {o, (r == '0), c, r};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        logic [N+2:0] alu_now;
        logic [N+2:0] alu_out;
        logic [N+2:0] pipe [4];

        assign alu_now = alu_fn(alu_op[g], alu_r2[g], alu_r3[g]);
        always @(posedge clk) begin
            pipe[0] <= alu_now;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign alu_out      = (L == 0) ? alu_now : pipe[(L == 0) ? 0 : L - 1];
        assign alu_r0[g]    = alu_out[N-1:0];
        assign alu_carry[g] = alu_out[N];
        assign alu_zero[g]  = alu_out[N+1];
        assign alu_ovf[g]   = alu_out[N+2];

        alu_issue_ctrl #(.N(N), .ALU_LAT(L)) dut (
            .clk        (clk),
            .rst        (rst),
            .instr_valid(instr_valid[g]),
            .instr_ready(instr_ready[g]),
            .instr_op   (instr_op[g]),
            .instr_rs   (instr_rs[g]),
            .instr_rt   (instr_rt[g]),
            .instr_rd   (instr_rd[g]),
            .ld_en      (ld_en[g]),
            .ld_addr    (ld_addr[g]),
            .ld_data    (ld_data[g]),
            .alu_r2     (alu_r2[g]),
            .alu_r3     (alu_r3[g]),
            .alu_op     (alu_op[g]),
            .alu_r0     (alu_r0[g]),
            .alu_ovf    (alu_ovf[g]),
            .alu_zero   (alu_zero[g]),
            .alu_carry  (alu_carry[g]),
            .res_valid  (res_valid[g]),
            .res_ready  (res_ready[g]),
            .res_data   (res_data[g]),
            .res_flags  (res_flags[g]),
            .busy       (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL lat%0d %s: observed %0h expected %0h", lat_of(cur_k), tag, obs, exp);
        end
    endtask

    task automatic ld(input int k, input logic [1:0] a, input logic [N-1:0] v);
        ld_en[k]   = 1'b1;
        ld_addr[k] = a;
        ld_data[k] = v;
        @(negedge clk);
        ld_en[k]   = 1'b0;
        rf_m[a]    = v;
    endtask

    // Issues one instruction from IDLE and follows it back to IDLE; optional same-cycle load
    // (co_ld), a load plus a stray instruction during EXEC (exec_ld), and `hold` stalled cycles.
    task automatic run_instr(input int k, input logic [2:0] op, input logic [1:0] rd,
                             input logic [1:0] rs, input logic [1:0] rt, input int hold,
                             input bit co_ld, input logic [1:0] la, input logic [N-1:0] lv,
                             input bit exec_ld, output logic [N-1:0] res, output logic [2:0] fl);
        logic [N+2:0] e;
        logic [N-1:0] a;
        logic [N-1:0] b;
        int edges;
        chk("instr_ready in idle", instr_ready[k], 1);
        res_ready[k]   = (hold == 0);
        instr_valid[k] = 1'b1;
        instr_op[k]    = op;
        instr_rd[k]    = rd;
        instr_rs[k]    = rs;
        instr_rt[k]    = rt;
        a = rf_m[rs];
        b = rf_m[rt];
        e = alu_fn(op, a, b);
        if (co_ld) begin
            ld_en[k]   = 1'b1;
            ld_addr[k] = la;
            ld_data[k] = lv;
            rf_m[la]   = lv;
        end
        @(negedge clk);
        instr_valid[k] = 1'b0;
        ld_en[k]       = 1'b0;
        edges = 0;
        chk("busy after accept", busy[k], 1);
        chk("instr_ready in exec", instr_ready[k], 0);
        chk("alu_r2 operand", alu_r2[k], a);
        chk("alu_r3 operand", alu_r3[k], b);
        chk("alu_op issued", alu_op[k], op);
        if (exec_ld) begin
            ld_en[k]       = 1'b1;
            ld_addr[k]     = la;
            ld_data[k]     = ~lv;
            instr_valid[k] = 1'b1;
            instr_op[k]    = 3'd1;
        end
        while (!res_valid[k] && edges < 40) begin
            @(negedge clk);
            ld_en[k]       = 1'b0;
            instr_valid[k] = 1'b0;
            edges++;
        end
        chk("result latency", edges, lat_of(k) + 1);
        chk("res_data", res_data[k], e[N-1:0]);
        chk("res_flags", res_flags[k], e[N+2:N]);
        res = res_data[k];
        fl  = res_flags[k];
        rf_m[rd] = e[N-1:0];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("stall res_valid", res_valid[k], 1);
            chk("stall res_data", res_data[k], e[N-1:0]);
            chk("stall res_flags", res_flags[k], e[N+2:N]);
            chk("stall instr_ready", instr_ready[k], 0);
        end
        res_ready[k] = 1'b1;
        @(negedge clk);
        chk("res_valid after handshake", res_valid[k], 0);
        chk("instr_ready after handshake", instr_ready[k], 1);
        chk("busy after handshake", busy[k], 0);
        chk("alu_op held in idle", alu_op[k], op);
        chk("alu_r2 held in idle", alu_r2[k], a);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] r;
        logic [2:0]   f;
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            instr_valid[k] = 1'b0;
            instr_op[k]    = 3'd0;
            instr_rs[k]    = 2'd0;
            instr_rt[k]    = 2'd0;
            instr_rd[k]    = 2'd0;
            ld_en[k]       = 1'b0;
            ld_addr[k]     = 2'd0;
            ld_data[k]     = '0;
            res_ready[k]   = 1'b1;
        end
        @(negedge clk);

        for (int k = 0; k < NI; k++) begin
            cur_k = k;
            rst = 1'b1;
            @(negedge clk);
            chk("reset instr_ready", instr_ready[k], 0);
            chk("reset busy", busy[k], 0);
            chk("reset res_valid", res_valid[k], 0);
            chk("reset res_data", res_data[k], 0);
            chk("reset res_flags", res_flags[k], 0);
            chk("reset alu_r2", alu_r2[k], 0);
            chk("reset alu_op", alu_op[k], 0);
            rst = 1'b0;
            @(negedge clk);
            chk("instr_ready after reset", instr_ready[k], 1);
            for (int i = 0; i < 4; i++) rf_m[i] = '0;

            // Reset in the middle of an ADD aborts it.
            ld(k, 2'd1, 32'd1000);
            ld(k, 2'd2, 32'd999);
            instr_valid[k] = 1'b1;
            instr_op[k] = 3'd2;
            instr_rd[k] = 2'd3;
            instr_rs[k] = 2'd1;
            instr_rt[k] = 2'd2;
            @(negedge clk);
            instr_valid[k] = 1'b0;
            chk("busy before abort", busy[k], 1);
            rst = 1'b1;
            #1;
            chk("abort busy", busy[k], 0);
            chk("abort res_valid", res_valid[k], 0);
            chk("abort instr_ready", instr_ready[k], 0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk("abort instr_ready after release", instr_ready[k], 1);
            chk("abort res_valid after release", res_valid[k], 0);
            for (int i = 0; i < 4; i++) rf_m[i] = '0;
            for (int i = 0; i < 4; i++) begin
                run_instr(k, 3'd0, 2'(i), 2'(i), 2'(i), 0, 1'b0, 2'd0, '0, 1'b0, r, f);
                chk("rf cleared by reset", r, 0);
            end

            // ADD 1000 + 999
            ld(k, 2'd1, 32'd1000);
            ld(k, 2'd2, 32'd999);
            run_instr(k, 3'd2, 2'd3, 2'd1, 2'd2, 0, 1'b0, 2'd0, '0, 1'b0, r, f);
            chk("add result", r, 1999);
            run_instr(k, 3'd0, 2'd3, 2'd3, 2'd3, 0, 1'b0, 2'd0, '0, 1'b0, r, f);
            chk("add writeback rf3", r, 1999);

            // SUB equal operands sets Zero
            ld(k, 2'd0, 32'hFFFF_FFFF);
            ld(k, 2'd1, 32'hFFFF_FFFF);
            run_instr(k, 3'd4, 2'd2, 2'd0, 2'd1, 0, 1'b0, 2'd0, '0, 1'b0, r, f);
            chk("sub result", r, 0);
            chk("sub zero flag", f[1], 1);

            // Backpressure for 5 cycles
            run_instr(k, 3'd2, 2'd3, 2'd3, 2'd0, 5, 1'b0, 2'd0, '0, 1'b0, r, f);

            // SLT signed, load during EXEC dropped, load with accept uses old operand
            ld(k, 2'd0, 32'hFFFF_FFFF);
            ld(k, 2'd1, 32'd5);
            run_instr(k, 3'd7, 2'd3, 2'd0, 2'd1, 0, 1'b0, 2'd0, '0, 1'b0, r, f);
            chk("slt result", r, 1);
            run_instr(k, 3'd1, 2'd2, 2'd1, 2'd1, 0, 1'b0, 2'd1, 32'd77, 1'b1, r, f);
            run_instr(k, 3'd0, 2'd1, 2'd1, 2'd1, 0, 1'b0, 2'd0, '0, 1'b0, r, f);
            chk("exec load dropped", r, 5);
            run_instr(k, 3'd2, 2'd3, 2'd1, 2'd1, 0, 1'b1, 2'd1, 32'd100, 1'b0, r, f);
            chk("same-cycle load old operand", r, 10);
            run_instr(k, 3'd0, 2'd1, 2'd1, 2'd1, 0, 1'b0, 2'd0, '0, 1'b0, r, f);
            chk("same-cycle load committed", r, 100);
            run_instr(k, 3'd2, 2'd3, 2'd1, 2'd1, 0, 1'b1, 2'd3, 32'd77, 1'b0, r, f);
            run_instr(k, 3'd0, 2'd3, 2'd3, 2'd3, 0, 1'b0, 2'd0, '0, 1'b0, r, f);
            chk("writeback beats load", r, 200);

            // Back-to-back MOV then ADD r2+r2 into r2
            ld(k, 2'd1, 32'd21);
            run_instr(k, 3'd0, 2'd2, 2'd1, 2'd1, 0, 1'b0, 2'd0, '0, 1'b0, r, f);
            chk("mov result", r, 21);
            run_instr(k, 3'd2, 2'd2, 2'd2, 2'd2, 0, 1'b0, 2'd0, '0, 1'b0, r, f);
            chk("add r2+r2", r, 42);
            run_instr(k, 3'd0, 2'd2, 2'd2, 2'd2, 0, 1'b0, 2'd0, '0, 1'b0, r, f);
            chk("rf2 after add", r, 42);

            // Random traffic against the model
            for (int n = 0; n < 24; n++) begin
                if ($urandom_range(0, 2) == 0) ld(k, 2'($urandom_range(0, 3)), $urandom);
                run_instr(k, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), r, f);
            end
            for (int i = 0; i < 4; i++) begin
                run_instr(k, 3'd0, 2'(i), 2'(i), 2'(i), 0, 1'b0, 2'd0, '0, 1'b0, r, f);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
